// File: rtl/npu_ofifo_arbiter_if.sv
// Handshake bundle for npu_ofifo_arbiter: slice FIFO read side plus the tagged result stream.
// master = arbiter side, slave = slice FIFOs / downstream consumer side.
interface npu_ofifo_arbiter_if #(
   parameter int NUM_SLICES  = 4,
   parameter int BATCH       = 3,
   parameter int ACCUM_DATAW = 32,
   parameter int SIDW        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
);
   logic [NUM_SLICES-1:0]                              i_ofifo_ready;
   logic [NUM_SLICES-1:0]                              o_ofifo_ren;
   logic signed [NUM_SLICES-1:0][BATCH-1:0][ACCUM_DATAW-1:0] i_ofifo_data;
   logic signed [BATCH-1:0][ACCUM_DATAW-1:0]           o_data;
   logic [SIDW-1:0]                                    o_sid;
   logic                                               o_valid;
   logic                                               i_ready;

   modport master (
      input  i_ofifo_ready, i_ofifo_data, i_ready,
      output o_ofifo_ren, o_data, o_sid, o_valid
   );

   modport slave (
      output i_ofifo_ready, i_ofifo_data, i_ready,
      input  o_ofifo_ren, o_data, o_sid, o_valid
   );
endinterface

// File: rtl/npu_ofifo_arbiter.sv
// Drains NUM_SLICES slice result FIFOs round-robin into one in-order stream tagged with slice id.
// Define NPU_OARB_BURST_EN to keep the grant on one slice for up to 4 consecutive reads.
module npu_ofifo_arbiter #(
   parameter int NUM_SLICES  = 4,
   parameter int BATCH       = 3,
   parameter int ACCUM_DATAW = 32,
   parameter int RD_LATENCY  = 1,
   parameter int SIDW        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
   input logic                 clk,
   input logic                 rst,
   npu_ofifo_arbiter_if.master bus
);
   localparam int DEPTH = RD_LATENCY + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(2 * DEPTH + 1);

`ifdef NPU_OARB_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif
   localparam logic [2:0] BURST_MAX = 3'd4;

   typedef logic [BATCH-1:0][ACCUM_DATAW-1:0] vec_t;

   logic [SIDW-1:0] last_sid;
   logic            have_cur;
   logic [2:0]      burst_cnt;
   logic            sticky;
   logic            credit_ok;
   logic            gnt_vld;
   logic [SIDW-1:0] gnt_sid;
   logic [SIDW-1:0] cand;

   logic            pipe_vld [RD_LATENCY];
   logic [SIDW-1:0] pipe_sid [RD_LATENCY];

   vec_t            mem_data [DEPTH];
   logic [SIDW-1:0] mem_sid  [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   occ, in_flight;
   logic            push, pop;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         in_flight = in_flight + CW'(pipe_vld[i]);
      end
   end

   // Reads still in the pipe already own a FIFO slot, so the FIFO can never overflow.
   assign credit_ok = (in_flight + occ) < CW'(DEPTH);

   assign sticky = BURST_EN && have_cur && bus.i_ofifo_ready[last_sid] && (burst_cnt < BURST_MAX);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_sid = '0;
      cand    = '0;
      if (!rst && credit_ok) begin
         if (sticky) begin
            gnt_vld = 1'b1;
            gnt_sid = last_sid;
         end else begin
            for (int i = 1; i <= NUM_SLICES; i++) begin
               cand = SIDW'((int'(last_sid) + i) % NUM_SLICES);
               if (!gnt_vld && bus.i_ofifo_ready[cand]) begin
                  gnt_vld = 1'b1;
                  gnt_sid = cand;
               end
            end
         end
      end
   end

   assign bus.o_ofifo_ren = gnt_vld ? (NUM_SLICES'(1) << gnt_sid) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_sid  <= SIDW'(NUM_SLICES - 1);
         have_cur  <= 1'b0;
         burst_cnt <= '0;
      end else if (gnt_vld) begin
         last_sid  <= gnt_sid;
         have_cur  <= 1'b1;
         burst_cnt <= sticky ? burst_cnt + 3'd1 : 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_vld[i] <= 1'b0;
            pipe_sid[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= gnt_vld;
         pipe_sid[0] <= gnt_sid;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_sid[i] <= pipe_sid[i-1];
         end
      end
   end

   assign pop  = bus.o_valid && bus.i_ready;
   assign push = pipe_vld[RD_LATENCY-1] && ((occ < CW'(DEPTH)) || pop);

   assign bus.o_valid = (occ != '0);
   assign bus.o_data  = mem_data[rd_ptr];
   assign bus.o_sid   = mem_sid[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_sid[i]  <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= bus.i_ofifo_data[pipe_sid[RD_LATENCY-1]];
            mem_sid[wr_ptr]  <= pipe_sid[RD_LATENCY-1];
            wr_ptr           <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end
endmodule
